// File: rtl/i2s_tx_serdes.sv
// Stereo I2S / left-justified / right-justified transmitter with sample FIFO and sck/ws generation.
// Build option: define I2S_TX_PRBS_EN to send LFSR words instead of zeros on underrun frames.
module i2s_tx_serdes #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            en_i,
  input  logic [1:0]                      mode_i,
  input  logic [DIV_WIDTH-1:0]            div_i,
  input  logic [2*DATA_WIDTH-1:0]         data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt_o,
  output logic                            sck_o,
  output logic                            ws_o,
  output logic                            sd_o,
  output logic                            underrun_o
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] LAST_B   = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] DW_B     = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] RJ_OFF   = BW'(SLOT_WIDTH - DATA_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  if (DATA_WIDTH < 8 || DATA_WIDTH > SLOT_WIDTH - 1) begin : g_bad_data_width
    $error("i2s_tx_serdes: DATA_WIDTH must lie in [8, SLOT_WIDTH-1]");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("i2s_tx_serdes: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [SW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 fifo_full, fifo_empty, push, pop;

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d, div_lat_q, div_lat_d, div_lim;
  logic                 sck_q, sck_d, ws_q, ws_d, sd_q, sd_d, underrun_q, underrun_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d, slot_pos, offset;
  logic [1:0]           mode_q, mode_d, frame_mode;
  logic [SW-1:0]        sh_q, sh_d, src, fill_word;
  logic                 fall, frame_start;

`ifdef I2S_TX_PRBS_EN
  localparam int LW = (SW > 23) ? SW : 23;
  logic [LW-1:0]        lfsr_q, lfsr_d;
  assign fill_word = lfsr_q[SW-1:0];
`else
  assign fill_word = '0;
`endif

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push       = valid_i && !fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= data_i;
  end

  // Divider limit is taken live while the counter sits at 0 so a new div_i only lands at a reload.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    div_lat_d   = div_lat_q;
    sck_d       = sck_q;
    bit_cnt_d   = bit_cnt_q;
    mode_d      = mode_q;
    sh_d        = sh_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    underrun_d  = 1'b0;
    pop         = 1'b0;
    fall        = 1'b0;
    frame_start = 1'b0;
    src         = sh_q;
    div_lim     = (div_cnt_q == '0) ? div_i : div_lat_q;
    frame_mode  = mode_q;
    offset      = BW'(1);
    slot_pos    = (bit_cnt_q >= SLOT_B) ? bit_cnt_q - SLOT_B : bit_cnt_q;
`ifdef I2S_TX_PRBS_EN
    lfsr_d      = lfsr_q;
`endif
    if (div_cnt_q == '0) div_lat_d = div_i;

    if (!en_i) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
      bit_cnt_d = '0;
      ws_d      = 1'b0;
      sd_d      = 1'b0;
    end else begin
      if (div_cnt_q == div_lim) begin
        div_cnt_d = '0;
        sck_d     = ~sck_q;
        fall      = sck_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end

      if (fall) begin
        frame_start = (bit_cnt_q == '0);
        if (frame_start) begin
          frame_mode = mode_i;
          mode_d     = mode_i;
          if (fifo_empty) begin
            underrun_d = 1'b1;
            src        = fill_word;
`ifdef I2S_TX_PRBS_EN
            lfsr_d     = {lfsr_q[LW-2:0], lfsr_q[22] ^ lfsr_q[17]};
`endif
          end else begin
            pop = 1'b1;
            src = fifo_mem[rd_ptr_q];
          end
        end

        case (frame_mode)
          2'd1:    offset = '0;
          2'd2:    offset = RJ_OFF;
          default: offset = BW'(1);
        endcase

        // Left and right words sit back to back, so one shift register feeds both slots.
        if (slot_pos >= offset && slot_pos < offset + DW_B) begin
          sd_d = src[SW-1];
          sh_d = {src[SW-2:0], 1'b0};
        end else begin
          sd_d = 1'b0;
          sh_d = src;
        end

        ws_d      = (bit_cnt_q >= SLOT_B);
        bit_cnt_d = (bit_cnt_q == LAST_B) ? '0 : bit_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      sck_q      <= 1'b0;
      bit_cnt_q  <= '0;
      mode_q     <= '0;
      sh_q       <= '0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
`ifdef I2S_TX_PRBS_EN
      lfsr_q     <= '1;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      sck_q      <= sck_d;
      bit_cnt_q  <= bit_cnt_d;
      mode_q     <= mode_d;
      sh_q       <= sh_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
`ifdef I2S_TX_PRBS_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign ready_o    = !fifo_full;
  assign fifo_cnt_o = cnt_q;
  assign sck_o      = sck_q;
  assign ws_o       = ws_q;
  assign sd_o       = sd_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serdes.sv
// Bench for i2s_tx_serdes: directed steps with random samples, checked against a frame-level model.
// With I2S_TX_PRBS_EN defined the model predicts LFSR words on underrun frames.
module tb_i2s_tx_serdes;

  localparam int DW  = 24;
  localparam int SW  = 32;
  localparam int FD  = 8;
  localparam int DVW = 8;

  logic                 clk_i   = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic                 en_i    = 1'b0;
  logic [1:0]           mode_i  = 2'd0;
  logic [DVW-1:0]       div_i   = 8'd1;
  logic [2*DW-1:0]      data_i  = '0;
  logic                 valid_i = 1'b0;
  logic                 ready_o, sck_o, ws_o, sd_o, underrun_o;
  logic [$clog2(FD):0]  fifo_cnt_o;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [2*DW-1:0] model_q[$];
  logic [2*DW-1:0] model_lfsr;

  i2s_tx_serdes #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(SW),
    .FIFO_DEPTH(FD),
    .DIV_WIDTH (DVW)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .div_i     (div_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .fifo_cnt_o(fifo_cnt_o),
    .sck_o     (sck_o),
    .ws_o      (ws_o),
    .sd_o      (sd_o),
    .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample per call; the model accepts it only while it believes the FIFO has room.
  task automatic applyStimulus(input logic [2*DW-1:0] word);
    data_i  = word;
    valid_i = 1'b1;
    if (model_q.size() < FD) model_q.push_back(word);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic waitFall(output int cycles);
    logic prev;
    bit   found;
    cycles = 0;
    found  = 1'b0;
    prev   = sck_o;
    while (!found && cycles < 64) begin
      @(negedge clk_i);
      cycles++;
      if (prev === 1'b1 && sck_o === 1'b0) found = 1'b1;
      prev = sck_o;
    end
    check_cnt++;
    assert (found) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL sck_fall: observed no falling sck in %0d clk, required one", cycles);
    end
  endtask

  function automatic logic expBit(input logic [2*DW-1:0] word, input logic [1:0] mode, input int b);
    int          pos;
    int          off;
    logic [DW-1:0] ch;
    pos = b % SW;
    off = (mode == 2'd1) ? 0 : (mode == 2'd2) ? SW - DW : 1;
    ch  = (b < SW) ? word[2*DW-1:DW] : word[DW-1:0];
    if (pos < off || pos >= off + DW) return 1'b0;
    return ch[DW-1-(pos-off)];
  endfunction

  // Follows nbits falling-sck events of one frame, starting at b=0.
  task automatic runFrame(input int nbits);
    logic [2*DW-1:0] word;
    logic [1:0]      fmode;
    bit              under;
    int              cyc;
    word  = '0;
    fmode = 2'd0;
    under = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      waitFall(cyc);
      if (b == 0) begin
        fmode = mode_i;
        under = (model_q.size() == 0);
        if (under) begin
`ifdef I2S_TX_PRBS_EN
          word       = model_lfsr;
          model_lfsr = {model_lfsr[2*DW-2:0], model_lfsr[22] ^ model_lfsr[17]};
`else
          word = '0;
`endif
        end else begin
          word = model_q.pop_front();
        end
      end
      checkOutput($sformatf("sck_interval_b%0d", b), 64'(cyc), 64'(2 * (int'(div_i) + 1)));
      checkOutput($sformatf("ws_b%0d", b), 64'(ws_o), 64'(b >= SW));
      checkOutput($sformatf("sd_b%0d", b), 64'(sd_o), 64'(expBit(word, fmode, b)));
      checkOutput($sformatf("underrun_b%0d", b), 64'(underrun_o), 64'((b == 0) && under));
      if (b == 5) mode_i = 2'($urandom_range(0, 3));
    end
  endtask

  function automatic logic [2*DW-1:0] randWord();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_sck"}, 64'(sck_o), 64'(0));
    checkOutput({tag, "_ws"},  64'(ws_o),  64'(0));
    checkOutput({tag, "_sd"},  64'(sd_o),  64'(0));
  endtask

  initial begin
    model_lfsr = '1;
    repeat (3) @(negedge clk_i);
    checkIdle("reset");
    checkOutput("reset_underrun", 64'(underrun_o), 64'(0));
    checkOutput("reset_cnt", 64'(fifo_cnt_o), 64'(0));
    checkOutput("reset_ready", 64'(ready_o), 64'(1));
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // I2S with the reference sample, sck period 4 clk.
    applyStimulus(48'hABCDEF_123456);
    checkOutput("push_cnt", 64'(fifo_cnt_o), 64'(1));
    mode_i = 2'd0;
    div_i  = 8'd1;
    en_i   = 1'b1;
    runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);
    checkIdle("disable_i2s");

    // Right-justified with the same sample.
    applyStimulus(48'hABCDEF_123456);
    mode_i = 2'd2;
    en_i   = 1'b1;
    runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);

    // Random samples, modes and dividers; each burst ends with an underrun frame.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) applyStimulus(randWord());
      div_i  = 8'($urandom_range(0, 3));
      mode_i = 2'($urandom_range(0, 3));
      en_i   = 1'b1;
      for (int f = 0; f < 4; f++) runFrame(64);
      en_i = 1'b0;
      @(negedge clk_i);
    end

    // Fill the FIFO while idle; the ninth push must be dropped.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(randWord());
      if (i == 7) checkOutput("fill7_ready", 64'(ready_o), 64'(1));
      if (i >= 8) begin
        checkOutput($sformatf("fill%0d_ready", i), 64'(ready_o), 64'(0));
        checkOutput($sformatf("fill%0d_cnt", i), 64'(fifo_cnt_o), 64'(FD));
      end
    end
    div_i = 8'd1;
    en_i  = 1'b1;
    for (int f = 0; f < 9; f++) runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);

    // Disable mid-frame at b=40; the interrupted sample is not resent.
    applyStimulus(randWord());
    applyStimulus(randWord());
    div_i = 8'($urandom_range(0, 2));
    en_i  = 1'b1;
    runFrame(41);
    en_i = 1'b0;
    @(negedge clk_i);
    checkIdle("midframe_off");
    checkOutput("midframe_cnt", 64'(fifo_cnt_o), 64'(1));
    repeat (9) @(negedge clk_i);
    en_i = 1'b1;
    runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);

    // One-cycle reset mid-frame with three entries queued flushes everything.
    for (int i = 0; i < 3; i++) applyStimulus(randWord());
    div_i = 8'd1;
    en_i  = 1'b1;
    runFrame(21);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_q.delete();
    model_lfsr = '1;
    checkIdle("midreset");
    checkOutput("midreset_underrun", 64'(underrun_o), 64'(0));
    checkOutput("midreset_cnt", 64'(fifo_cnt_o), 64'(0));
    checkOutput("midreset_ready", 64'(ready_o), 64'(1));
    runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(randWord());
    en_i = 1'b1;
    runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);

`ifdef I2S_TX_PRBS_EN
    // Two back-to-back underrun frames carry successive LFSR words.
    en_i = 1'b1;
    runFrame(64);
    runFrame(64);
    en_i = 1'b0;
    @(negedge clk_i);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serdes.md
Name: i2s_tx_serdes

Overview:
- Parametrised I2S transmitter and bus master.
- Successor to the behavioural mic source model. It is synthesizable, runs on one system clock and generates sck_o/ws_o itself.
- Serialises stereo samples from an internal FIFO.
- Supports I2S, left-justified and right-justified framing, with configurable data and slot widths.
- Sits between the SoC audio register block (sample push) and the external codec/DAC pins, and doubles as stimulus for the receiver bench.

Parameters:
- DATA_WIDTH, 24: bits per channel sample; elaboration error unless 8 <= DATA_WIDTH <= SLOT_WIDTH-1.
- SLOT_WIDTH, 32: sck periods per channel slot; frame = 2*SLOT_WIDTH sck periods.
- FIFO_DEPTH, 8: stereo sample entries; power of two, >= 2.
- DIV_WIDTH, 8: width of clock divider input.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset; synchronous to clk_i, active-low.
- en_i  input  1  transmitter enable.
- mode_i  input  2  framing: 0 = I2S, 1 = left-justified, 2 = right-justified, 3 = treated as I2S.
- div_i  input  DIV_WIDTH  sck half-period = div_i+1 clk_i cycles.
- data_i  input  2*DATA_WIDTH  stereo sample; [2*DATA_WIDTH-1:DATA_WIDTH] = left, [DATA_WIDTH-1:0] = right.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept; equals !full.
- fifo_cnt_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- sck_o  output  1  serial bit clock.
- ws_o  output  1  word select; 0 = left, 1 = right.
- sd_o  output  1  serial data, MSB first.
- underrun_o  output  1  one-cycle pulse, frame started with FIFO empty.

Behaviour:
- Reset (rst_n_i=0 at posedge clk_i):
  - sck_o=0, ws_o=0, sd_o=0, underrun_o=0.
  - FIFO empty, fifo_cnt_o=0, ready_o=1.
  - Divider counter=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts immediately; no partial state survives.
- FIFO:
  - Push on valid_i&&ready_o.
  - Pop only at frame start.
  - Simultaneous push and pop: count unchanged.
  - Full: ready_o=0, valid_i ignored.
  - No empty-bypass: a push in the same cycle as a frame-start pop is not seen by that pop.
- Divider:
  - Counts 0..div_i. On terminal count sck_o toggles and the counter reloads 0.
  - div_i=0 gives sck_o = clk_i/2.
  - div_i is re-sampled at every reload.
- Falling-sck event: cycle where sck_o goes 1->0, registered. All output changes occur with it; bit counter b (0..2*SLOT_WIDTH-1) advances with it.
  - On b=0: sample mode_i, pop FIFO into left/right shift registers.
  - If the FIFO is empty, load zeros and pulse underrun_o.
- MSB offset within a slot:
  - I2S = 1.
  - Left-justified = 0.
  - Right-justified = SLOT_WIDTH-DATA_WIDTH.
- Slot bits:
  - Bits before the offset and after the LSB are driven 0.
  - ws_o=0 for b in [0,SLOT_WIDTH-1], ws_o=1 otherwise. In I2S this places the ws edge one sck before the MSB.
- Latency: the first MSB appears on sd_o at the falling event for b = offset, after the frame-start pop.
- en_i=0 at any time, next clk:
  - Divider and bit counters cleared; sck_o, ws_o and sd_o forced 0.
  - FIFO contents and pushes preserved.
  - Re-enable starts a fresh frame at b=0 on the first falling event.
- mode_i/div_i changes mid-frame: framing uses the sampled mode until the frame ends; divider changes apply at the next reload.

Optional Feature:
- Macro I2S_TX_PRBS_EN.
- Defined: on underrun, shift registers load from a 2*DATA_WIDTH-bit Fibonacci LFSR, x^23+x^18+1 applied over its low 23 bits. The LFSR is seeded to all-ones at reset and advances once per underrun frame. underrun_o still pulses.
- Undefined: underrun frames carry zeros and no LFSR logic exists.

Test Plan:
- Reset, then push 0xABCDEF/0x123456, mode 0, div_i=1 -> sck period 4 clk; ws_o low 32 sck; sd_o = 0, then 1010_1011..., left LSB at b=24; right MSB at b=33.
- Mode 2, same sample -> left MSB at b=8, LSB at b=31, ws_o falls at b=0; bits 0..7 zero.
- Push 9 samples with en_i=0 -> ready_o=0 after 8, fifo_cnt_o=8; 9th dropped; enable -> frames transmit samples 1..8 in order, then underrun_o pulses at the 9th frame start with sd_o all zero.
- Drop en_i at b=40, raise after 10 clk -> outputs 0 within 1 clk; new frame starts at b=0 with the next FIFO entry; the interrupted sample is not resent.
- Assert rst_n_i low for 1 clk mid-frame with 3 entries -> all outputs 0, fifo_cnt_o=0 next cycle.
- With I2S_TX_PRBS_EN defined, empty FIFO -> two consecutive frames carry distinct nonzero LFSR words and underrun_o pulses twice.
